// File: rtl/sd_cmd_phys.sv
// SD host CMD-line physical layer: serializes 48-bit command frames with CRC7 and
// deserializes/checks 48- or 136-bit card responses, returning status and payload.
module sd_cmd_phys #(
  parameter int NCR_TIMEOUT = 64,
  parameter int NCC_GAP     = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         cmd_start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_argument,
  input  logic [1:0]   resp_type,
  input  logic         cmd_in,
  output logic         cmd_out,
  output logic         cmd_oe,
  output logic         busy,
  output logic         done,
  output logic [127:0] response,
  output logic         crc_err,
  output logic         end_bit_err,
  output logic         index_err,
  output logic         timeout_err
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, GAP} state_t;

  state_t       state, state_nxt;
  logic [7:0]   cnt;
  logic [5:0]   idx_q;
  logic [1:0]   type_q;
  logic [39:0]  tx_sh;
  logic [6:0]   crc;
  logic [126:0] rx;

  logic       accept, long_rsp, recv_last, wait_to, gap_end, crc_win;
  logic [7:0] last_bit;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  // done is registered into the first IDLE cycle; starts in that cycle are ignored
  assign accept    = (state == IDLE) && cmd_start && !done;
  assign long_rsp  = (type_q == 2'b10);
  assign last_bit  = long_rsp ? 8'd135 : 8'd47;
  assign recv_last = (cnt == last_bit);
  assign wait_to   = (cnt == 8'(NCR_TIMEOUT - 1));
  assign gap_end   = (cnt == 8'(NCC_GAP - 1));
  // CRC covers frame bits [47:8] for short responses, [127:8] for long ones
  assign crc_win   = long_rsp ? (cnt >= 8'd8 && cnt <= 8'd127) : (cnt <= 8'd39);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = SEND;
      SEND:      if (cnt == 8'd47) state_nxt = (type_q == 2'b00) ? GAP : WAIT_RESP;
      WAIT_RESP: if (!cmd_in) state_nxt = RECV;
                 else if (wait_to) state_nxt = GAP;
      RECV:      if (recv_last) state_nxt = GAP;
      GAP:       if (gap_end) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_oe  = (state == SEND);
    busy    = (state != IDLE);
    cmd_out = 1'b1;
    if (state == SEND) begin
      if (cnt < 8'd40)      cmd_out = tx_sh[39];
      else if (cnt < 8'd47) cmd_out = crc[6];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt         <= '0;
      idx_q       <= '0;
      type_q      <= '0;
      tx_sh       <= '0;
      crc         <= '0;
      rx          <= '0;
      done        <= 1'b0;
      response    <= '0;
      crc_err     <= 1'b0;
      end_bit_err <= 1'b0;
      index_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          idx_q       <= cmd_index;
          type_q      <= resp_type;
          tx_sh       <= {2'b01, cmd_index, cmd_argument};
          crc         <= '0;
          rx          <= '0;
          cnt         <= '0;
          crc_err     <= 1'b0;
          end_bit_err <= 1'b0;
          index_err   <= 1'b0;
          timeout_err <= 1'b0;
        end
        SEND: begin
          cnt <= cnt + 8'd1;
          if (cnt < 8'd40) begin
            crc   <= crc7_step(crc, tx_sh[39]);
            tx_sh <= tx_sh << 1;
          end else begin
            crc <= {crc[5:0], 1'b0};
          end
          if (cnt == 8'd47) begin
            cnt <= '0;
            crc <= '0;
          end
        end
        WAIT_RESP: begin
          cnt <= cnt + 8'd1;
          if (!cmd_in) begin
            // start bit is bit 0 of the count; a zero leaves the zero-init CRC unchanged
            cnt <= 8'd1;
            crc <= '0;
            rx  <= {rx[125:0], cmd_in};
          end else if (wait_to) begin
            timeout_err <= 1'b1;
            cnt         <= '0;
          end
        end
        RECV: begin
          cnt <= cnt + 8'd1;
          if (crc_win) crc <= crc7_step(crc, cmd_in);
          if (!recv_last) begin
            rx <= {rx[125:0], cmd_in};
          end else begin
            // rx[k] holds frame bit k+1; the end bit is still on cmd_in
            cnt         <= '0;
            end_bit_err <= ~cmd_in;
            crc_err     <= (type_q != 2'b11) && (crc != rx[6:0]);
            index_err   <= (type_q == 2'b01) && (rx[44:39] != idx_q);
            response    <= long_rsp ? {8'h00, rx[126:7]} : {96'h0, rx[38:7]};
          end
        end
        GAP: begin
          cnt <= cnt + 8'd1;
          if (gap_end) begin
            done <= 1'b1;
            cnt  <= '0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/sd_cmd_phys.md
Name: sd_cmd_phys

Overview:
- Physical layer of the SD host CMD line.
- Accepts a command request (index, argument, response type) from the CMD controller in the sd_host top.
- Serializes the 48-bit command frame with CRC7 onto the card command line.
- Deserializes the card response and checks it, then hands status and response bits back to the CMD controller for the Response registers.

Parameters:
- NCR_TIMEOUT, 64, cycles allowed after the command end bit for the response start bit to appear.
- NCC_GAP, 8, idle cycles between end of transaction and return to IDLE.

Ports:
- CLK  in  1  card clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle request; accepted only when busy=0.
- cmd_index  in  6  command index.
- cmd_argument  in  32  command argument.
- resp_type  in  2  00 none, 01 48-bit, 10 136-bit, 11 48-bit without CRC/index check.
- cmd_in  in  1  sampled card CMD line.
- cmd_out  out  1  serialized command bit.
- cmd_oe  out  1  output enable for the CMD pad.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle completion pulse.
- response  out  128  received response payload.
- crc_err  out  1  response CRC7 mismatch.
- end_bit_err  out  1  response end bit was 0.
- index_err  out  1  48-bit response index differs from cmd_index.
- timeout_err  out  1  no start bit within NCR_TIMEOUT.

Behaviour:
- Reset values (RESET=0): state IDLE, cmd_out=1, cmd_oe=0, busy=0, done=0, response=0, all error flags 0. Reset takes effect immediately mid-frame and aborts the transaction with no done pulse.
- States: IDLE, SEND, WAIT_RESP, RECV, GAP.
- IDLE:
  - cmd_start=1 latches index, argument and resp_type; clears all error flags; busy=1; go to SEND.
  - cmd_start while busy=1 is ignored.
- SEND:
  - The frame occupies 48 consecutive cycles starting the cycle after accept, MSB first, with cmd_oe=1.
  - Frame bits: 0, 1, index[5:0], arg[31:0], CRC7[6:0], 1.
  - CRC7 polynomial is x^7+x^3+1, zero init, computed serially over the first 40 bits.
  - After the end bit, cmd_oe=0 and cmd_out=1.
  - resp_type=00 goes to GAP; otherwise WAIT_RESP.
- WAIT_RESP:
  - A 7-bit counter runs from 0. The first cycle with cmd_in=0 is the start bit; go to RECV.
  - If the counter reaches NCR_TIMEOUT with no start bit: timeout_err=1, go to GAP.
- RECV:
  - Shift cmd_in every cycle for the remaining 47 (48-bit) or 135 (136-bit) bits; bit count includes the start bit.
  - 48-bit response:
    - response[31:0] = received bits [39:8]; response[127:32] = 0.
    - CRC7 is computed over bits [47:8] and compared to [7:1].
    - The index in bits [45:40] is compared to cmd_index.
  - 136-bit response:
    - response[119:0] = bits [127:8]; response[127:120] = 0.
    - CRC7 is computed over bits [127:8]; no index check.
  - resp_type=11: crc_err and index_err are never set.
  - The end bit sampled as 0 sets end_bit_err.
  - Error flags and response update on the same edge the end bit is sampled; then go to GAP.
- GAP:
  - Count NCC_GAP cycles, then done=1 for one cycle, busy=0, and go to IDLE.
  - response and error flags hold until the next accept.
  - A cmd_start arriving in the done cycle is accepted only on the following cycle, because busy is cleared with done.
- Latency: accept edge N → start bit on cmd_out from N+1. Response bits are never sampled while cmd_oe=1.

Test Plan:
- CMD0, argument 0x00000000, resp_type 00 → cmd_out sequence 0x40_00000000_95 over 48 cycles. Then cmd_oe=0, done after NCC_GAP cycles, no error flags set.
- CMD8, argument 0x000001AA, resp_type 01; card drives 0x08_000001AA_13 starting 5 cycles after the end bit. Required result: frame sent is 0x48_000001AA_87, response[31:0]=0x000001AA, all error flags 0.
- Same exchange with one argument bit flipped in the response → crc_err=1 and done pulses. Separately, response index 0x09 → index_err=1.
- Any command with resp_type 01 and cmd_in held 1 → timeout_err=1 exactly NCR_TIMEOUT cycles after the end bit, followed by done. Repeat with resp_type 11 and end bit driven 0 → end_bit_err=1 only.
- 136-bit exchange (CMD2), card sends a known CID with valid CRC → response[119:0] = CID[127:8], all error flags 0. Also pulse cmd_start mid-SEND → ignored; the frame is unchanged.
- Assert RESET at bit 20 of SEND → cmd_oe=0 and busy=0 immediately, no done. After release, a new CMD0 transmits correctly.
